// File: rtl/pool_engine.sv
// pool_engine: max / average pooling over a CH x R x C picture held in BRAM.
// One window sample is read per cycle; each output pixel costs K*K+2 cycles.
module pool_engine #(
    parameter int WIDTH      = 8,
    parameter int MEMADDRBIT = 17,
    parameter int DIMBIT     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [2:0]            ksize,
    input  logic [2:0]            stride,
    input  logic [DIMBIT-1:0]     dim_r,
    input  logic [DIMBIT-1:0]     dim_c,
    input  logic [DIMBIT-1:0]     dim_ch,
    input  logic [MEMADDRBIT-1:0] in_base,
    input  logic [MEMADDRBIT-1:0] out_base,
    output logic [MEMADDRBIT-1:0] rd_addr,
    input  logic [WIDTH-1:0]      rd_data,
    output logic                  wr_en,
    output logic [MEMADDRBIT-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int A  = MEMADDRBIT;
    localparam int AW = WIDTH + 4;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;
    state_t state_q, state_d;

    // latched job configuration
    logic              mode_q, mode_d;
    logic [2:0]        k_q, k_d, s_q, s_d;
    logic [DIMBIT-1:0] r_q, r_d, c_q, c_d, chn_q, chn_d;
    logic [A-1:0]      in_base_q, in_base_d, out_base_q, out_base_d;
    logic [DIMBIT-1:0] ro_q, ro_d, co_q, co_d;
    logic              bad_q, bad_d;
    // traversal counters
    logic [DIMBIT-1:0] ch_q, ch_d, orow_q, orow_d, ocol_q, ocol_d;
    logic [2:0]        wr_q, wr_d, wc_q, wc_d;
    logic [A-1:0]      out_idx_q, out_idx_d, rd_hold_q, rd_hold_d;
    // read-return tracking and accumulator
    logic              rd_pend_q, rd_pend_d, rd_first_q, rd_first_d;
    logic signed [AW-1:0] acc_q, acc_d;

    logic              cfg_bad, win_last, pix_last;
    logic [2:0]        s_div;
    logic [A-1:0]      rd_cur, a_row, a_col;
    logic signed [AW-1:0] samp, avg_sh;

    // illegal configuration, window / job end conditions, current read address
    always_comb begin
        cfg_bad  = (k_q == 3'd0) || (s_q == 3'd0) || (DIMBIT'(k_q) > r_q) ||
                   (DIMBIT'(k_q) > c_q) || (chn_q == '0) ||
                   (mode_q && !(k_q == 3'd1 || k_q == 3'd2 || k_q == 3'd4));
        s_div    = (s_q == 3'd0) ? 3'd1 : s_q;
        win_last = (wc_q == k_q - 3'd1) && (wr_q == k_q - 3'd1);
        pix_last = (ocol_q == co_q - DIMBIT'(1)) && (orow_q == ro_q - DIMBIT'(1)) &&
                   (ch_q == chn_q - DIMBIT'(1));
        a_row    = A'(orow_q) * A'(s_q) + A'(wr_q);
        a_col    = A'(ocol_q) * A'(s_q) + A'(wc_q);
        rd_cur   = in_base_q + A'(ch_q) * A'(r_q) * A'(c_q) + a_row * A'(c_q) + a_col;
        samp     = AW'($signed(rd_data));
        // shift of log2(K*K): K is 1, 2 or 4 on any legal average job
        avg_sh   = (k_q == 3'd4) ? (acc_q >>> 4) : (k_q == 3'd2) ? (acc_q >>> 2) : acc_q;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CHECK;
            S_CHECK: state_d = cfg_bad ? S_DONE : S_READ;
            S_READ:  if (win_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = pix_last ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; write bus is zero outside the WRITE cycle
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        err     = (state_q == S_DONE) && bad_q;
        wr_en   = (state_q == S_WRITE);
        wr_addr = (state_q == S_WRITE) ? out_base_q + out_idx_q : '0;
        wr_data = '0;
        if (state_q == S_WRITE) wr_data = mode_q ? avg_sh[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rd_addr = (state_q == S_READ) ? rd_cur : rd_hold_q;
    end

    // datapath next values: config latch, counters, accumulator
    always_comb begin
        mode_d = mode_q; k_d = k_q; s_d = s_q; r_d = r_q; c_d = c_q; chn_d = chn_q;
        in_base_d = in_base_q; out_base_d = out_base_q; ro_d = ro_q; co_d = co_q;
        bad_d = bad_q; ch_d = ch_q; orow_d = orow_q; ocol_d = ocol_q;
        wr_d = wr_q; wc_d = wc_q; out_idx_d = out_idx_q;
        rd_hold_d  = (state_q == S_READ) ? rd_cur : rd_hold_q;
        rd_pend_d  = (state_q == S_READ);
        rd_first_d = (state_q == S_READ) && (wc_q == 3'd0) && (wr_q == 3'd0);
        acc_d = acc_q;
        if (rd_pend_q) begin
            if (rd_first_q)  acc_d = samp;
            else if (mode_q) acc_d = acc_q + samp;
            else if (samp > acc_q) acc_d = samp;
        end
        case (state_q)
            S_IDLE: if (start) begin
                mode_d = mode; k_d = ksize; s_d = stride; r_d = dim_r; c_d = dim_c;
                chn_d = dim_ch; in_base_d = in_base; out_base_d = out_base; bad_d = 1'b0;
            end
            S_CHECK: begin
                bad_d = cfg_bad;
                ro_d  = (r_q - DIMBIT'(k_q)) / DIMBIT'(s_div) + DIMBIT'(1);
                co_d  = (c_q - DIMBIT'(k_q)) / DIMBIT'(s_div) + DIMBIT'(1);
                ch_d = '0; orow_d = '0; ocol_d = '0; wr_d = '0; wc_d = '0; out_idx_d = '0;
            end
            S_READ: begin
                if (wc_q == k_q - 3'd1) begin
                    wc_d = '0;
                    wr_d = (wr_q == k_q - 3'd1) ? 3'd0 : wr_q + 3'd1;
                end else begin
                    wc_d = wc_q + 3'd1;
                end
            end
            S_WRITE: begin
                out_idx_d = out_idx_q + A'(1);
                if (ocol_q == co_q - DIMBIT'(1)) begin
                    ocol_d = '0;
                    if (orow_q == ro_q - DIMBIT'(1)) begin
                        orow_d = '0;
                        ch_d   = ch_q + DIMBIT'(1);
                    end else begin
                        orow_d = orow_q + DIMBIT'(1);
                    end
                end else begin
                    ocol_d = ocol_q + DIMBIT'(1);
                end
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0; k_q <= '0; s_q <= '0; r_q <= '0; c_q <= '0; chn_q <= '0;
            in_base_q <= '0; out_base_q <= '0; ro_q <= '0; co_q <= '0; bad_q <= 1'b0;
            ch_q <= '0; orow_q <= '0; ocol_q <= '0; wr_q <= '0; wc_q <= '0;
            out_idx_q <= '0; rd_hold_q <= '0; rd_pend_q <= 1'b0; rd_first_q <= 1'b0;
            acc_q <= '0;
        end else begin
            mode_q <= mode_d; k_q <= k_d; s_q <= s_d; r_q <= r_d; c_q <= c_d; chn_q <= chn_d;
            in_base_q <= in_base_d; out_base_q <= out_base_d; ro_q <= ro_d; co_q <= co_d;
            bad_q <= bad_d; ch_q <= ch_d; orow_q <= orow_d; ocol_q <= ocol_d;
            wr_q <= wr_d; wc_q <= wc_d; out_idx_q <= out_idx_d; rd_hold_q <= rd_hold_d;
            rd_pend_q <= rd_pend_d; rd_first_q <= rd_first_d; acc_q <= acc_d;
        end
    end
endmodule
